click_pair_generator: RTL

Synthesizable two-channel detector-click emulator for on-chip self-test of the coincidence path. It produces programmable pulse pairs on `x` and `y` with a set period, pulse width and relative skew, and counts the pairs it emits. It drives the `x`/`y` inputs of `two_fold_coincidence` in place of the real detector inputs. Known pair counts can then be checked against the coincidence counter.

---
 rtl/click_pair_generator_pkg.sv | 15 +
 rtl/click_pair_generator_if.sv | 29 ++
 rtl/click_pair_generator_lfsr16.sv | 25 ++
 rtl/click_pair_generator.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/click_pair_generator_pkg.sv
// click_gen_pkg: shared types and constants for the click pair generator.
// Optional build macro: CLICK_GEN_JITTER_EN (per-pair skew jitter from an LFSR).
package click_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int CW_DEFAULT = 16;

endpackage

// File: rtl/click_pair_generator_if.sv
// Control and click bundle between a burst master and the click pair generator.
// Optional build macro: CLICK_GEN_JITTER_EN (no effect on this bundle).
interface click_pair_generator_if
    import click_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT
);
    logic          start;
    logic          stop;
    logic [CW-1:0] period;
    logic [CW-1:0] width;
    logic [CW-1:0] skew;
    logic [CW-1:0] n_pairs;
    logic          x;
    logic          y;
    logic          busy;
    logic          done;
    logic [CW-1:0] pair_count;

    modport master (
        output start, stop, period, width, skew, n_pairs,
        input  x, y, busy, done, pair_count
    );

    modport slave (
        input  start, stop, period, width, skew, n_pairs,
        output x, y, busy, done, pair_count
    );
endinterface

// File: rtl/click_pair_generator_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), reloadable seed.
// Optional build macro: CLICK_GEN_JITTER_EN (only instantiated when defined).
module lfsr16
    import click_gen_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    output logic [15:0] q
);
    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[14:0], fb};
        end
    end
endmodule

// File: rtl/click_pair_generator.sv
// click_pair_generator: programmable x/y pulse-pair bursts for coincidence self-test.
// Optional build macro: CLICK_GEN_JITTER_EN (skew += lfsr[1:0], new value per pair).
module click_pair_generator
    import click_gen_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input logic                   clock,
    input logic                   reset,
    click_pair_generator_if.slave bus
);
    localparam int XW = CW + 2;

    state_t        state;
    logic [CW-1:0] t;
    logic [CW-1:0] period_r;
    logic [CW-1:0] width_r;
    logic [CW-1:0] skew_r;
    logic [CW-1:0] n_pairs_r;
    logic [CW-1:0] count;
    logic          stop_seen;
    logic          x_q;
    logic          y_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] t_last;
    logic [CW-1:0] count_next;
    logic          wrap;
    logic          last_pair;
    logic          x_lvl;
    logic          y_lvl;
    logic [XW-1:0] t_w;
    logic [XW-1:0] width_w;
    logic [XW-1:0] skew_eff;

    assign t_last     = (period_r == '0) ? '0 : period_r - CW'(1);
    assign wrap       = (t == t_last);
    assign count_next = (count == '1) ? count : count + CW'(1);
    assign last_pair  = (count_next == n_pairs_r) || stop_seen || bus.stop;

`ifdef CLICK_GEN_JITTER_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (state == IDLE && bus.start),
        .step  (state == RUN && wrap),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:2];
    assign skew_eff    = XW'(skew_r) + XW'(lfsr_q[1:0]);
`else
    assign skew_eff = XW'(skew_r);
`endif

    // Two spare bits keep skew+width from wrapping; truncation at the
    // pair boundary falls out because t never exceeds p_eff-1.
    assign t_w     = XW'(t);
    assign width_w = XW'(width_r);
    assign x_lvl   = (t_w < width_w);
    assign y_lvl   = (t_w >= skew_eff) && (t_w < skew_eff + width_w);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            t         <= '0;
            period_r  <= '0;
            width_r   <= '0;
            skew_r    <= '0;
            n_pairs_r <= '0;
            count     <= '0;
            stop_seen <= 1'b0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    x_q       <= 1'b0;
                    y_q       <= 1'b0;
                    done_q    <= 1'b0;
                    stop_seen <= 1'b0;
                    if (bus.start) begin
                        period_r  <= bus.period;
                        width_r   <= bus.width;
                        skew_r    <= bus.skew;
                        n_pairs_r <= bus.n_pairs;
                        count     <= '0;
                        t         <= '0;
                        if (bus.n_pairs == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    x_q <= x_lvl;
                    y_q <= y_lvl;
                    if (bus.stop) begin
                        stop_seen <= 1'b1;
                    end
                    if (wrap) begin
                        t     <= '0;
                        count <= count_next;
                        if (last_pair) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        t <= t + CW'(1);
                    end
                end
                DONE: begin
                    x_q       <= 1'b0;
                    y_q       <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    stop_seen <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pair_count = count;
endmodule
